// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//   Drains a show-ahead synchronous FIFO and re-emits its contents as
//   fixed-length bursts (BURST_LEN beats) on a valid/ready stream. When fewer
//   than BURST_LEN entries sit in the FIFO for TIMEOUT consecutive idle
//   cycles, the stragglers are flushed out as single-beat bursts.
//
// Ports
//   clk, rstn          clock (rising edge), async active-low reset
//   i_en               permits new bursts (a started burst always completes)
//   o_fifo_rden        FIFO pop strobe (combinational)
//   i_fifo_rddata      FIFO head data, valid whenever !i_fifo_empty
//   i_fifo_empty       FIFO empty
//   i_fifo_alm_empty   FIFO holds fewer than BURST_LEN entries
//   o_valid/o_data     output beat
//   o_first/o_last     burst framing, qualified by o_valid
//   i_ready            downstream accepts the beat
//   o_busy             FSM is not IDLE
//   o_burst_cnt        completed bursts (normal and flush), wraps
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int DATA_W    = 128,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_en,
  output logic              o_fifo_rden,
  input  logic [DATA_W-1:0] i_fifo_rddata,
  input  logic              i_fifo_empty,
  input  logic              i_fifo_alm_empty,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_first,
  output logic              o_last,
  input  logic              i_ready,
  output logic              o_busy,
  output logic [15:0]       o_burst_cnt
);

  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [TMR_W-1:0]  TMO       = TMR_W'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [BEAT_W-1:0]   r_beat,  w_beat_nxt;
  logic [TMR_W-1:0]    r_tmr,   w_tmr_nxt;

  logic                r_valid;
  logic                r_first;
  logic                r_last;
  logic [DATA_W-1:0]   r_data;
  logic [15:0]         r_cnt;

  logic                w_can_load;
  logic                w_pop;
  logic                w_ld_first;
  logic                w_ld_last;
  logic                w_accept;

  // Output register can take a beat when empty or being drained this cycle.
  assign w_can_load = !r_valid || i_ready;
  assign w_accept   = r_valid && i_ready;

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_beat  <= '0;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
      r_tmr   <= w_tmr_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state / pop decision
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_tmr_nxt   = r_tmr;
    w_pop       = 1'b0;
    w_ld_first  = 1'b0;
    w_ld_last   = 1'b0;

    case (r_state)
      IDLE: begin
        // Decision cycle only: never pops, so bursts are separated by >=1 cycle.
        if (i_en && !i_fifo_alm_empty && !i_fifo_empty) begin
          w_state_nxt = BURST;
          w_beat_nxt  = '0;
          w_tmr_nxt   = '0;
        end else if (i_en && !i_fifo_empty && i_fifo_alm_empty) begin
          // Starved: timer is compared before incrementing, so the flush
          // begins TIMEOUT+1 cycles after starvation is first sampled.
          if (r_tmr == TMO) begin
            w_state_nxt = FLUSH;
            w_tmr_nxt   = '0;
          end else begin
            w_tmr_nxt = r_tmr + 1'b1;
          end
        end else begin
          w_tmr_nxt = '0;
        end
      end

      BURST: begin
        // Entry guaranteed BURST_LEN entries and nothing else pops, so
        // i_fifo_empty only matters as a safety guard here.
        w_pop      = w_can_load && !i_fifo_empty;
        w_ld_first = (r_beat == '0);
        w_ld_last  = (r_beat == LAST_BEAT);
        if (w_pop) begin
          if (r_beat == LAST_BEAT) begin
            w_state_nxt = IDLE;
            w_beat_nxt  = '0;
          end else begin
            w_beat_nxt = r_beat + 1'b1;
          end
        end
      end

      FLUSH: begin
        w_pop      = w_can_load && !i_fifo_empty;
        w_ld_first = 1'b1;
        w_ld_last  = 1'b1;
        // Leave when disabled, when drained, or when enough data has piled
        // up (without a pop this cycle) to issue a full burst instead.
        if (!i_en || (!w_pop && (i_fifo_empty || !i_fifo_alm_empty)))
          w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
        w_beat_nxt  = '0;
        w_tmr_nxt   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output register and completed-burst counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid <= 1'b0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      // A load while the old beat is accepted replaces it with no bubble.
      if (w_pop) begin
        r_valid <= 1'b1;
        r_data  <= i_fifo_rddata;
        r_first <= w_ld_first;
        r_last  <= w_ld_last;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_accept && r_last)
        r_cnt <= r_cnt + 16'd1;
    end
  end

  assign o_fifo_rden = w_pop;
  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_first     = r_first;
  assign o_last      = r_last;
  assign o_busy      = (r_state != IDLE);
  assign o_burst_cnt = r_cnt;

endmodule

// File: tb/tb_fifo_burst_reader.sv
`timescale 1ns/1ps
module tb_fifo_burst_reader;
  localparam int DATA_W    = 128;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              i_en = 1'b0;
  logic              i_ready = 1'b0;
  logic              o_fifo_rden;
  logic [DATA_W-1:0] i_fifo_rddata = '0;
  logic              i_fifo_empty = 1'b1;
  logic              i_fifo_alm_empty = 1'b1;
  logic              o_valid, o_first, o_last, o_busy;
  logic [DATA_W-1:0] o_data;
  logic [15:0]       o_burst_cnt;

  always #5 clk = ~clk;

  fifo_burst_reader #(.DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstn(rstn), .i_en(i_en), .o_fifo_rden(o_fifo_rden),
    .i_fifo_rddata(i_fifo_rddata), .i_fifo_empty(i_fifo_empty),
    .i_fifo_alm_empty(i_fifo_alm_empty), .o_valid(o_valid), .o_data(o_data),
    .o_first(o_first), .o_last(o_last), .i_ready(i_ready), .o_busy(o_busy),
    .o_burst_cnt(o_burst_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Behavioural environment: FIFO contents, expected output stream, framing
  // position inside the current burst and a model of the completed-burst count.
  logic [DATA_W-1:0] fq[$];
  logic [DATA_W-1:0] sb[$];
  logic [DATA_W-1:0] dv[8];
  int                pos;
  logic [15:0]       cnt_m;
  int                pops;
  int                acc;
  logic              rden_now;

  typedef struct {
    logic start;           // reset and preload dv[0..3] before this row
    logic en, rdy;
    logic rden, vld;
    int   didx;
    logic first, last;
    logic [15:0] cnt;
  } vec_t;
  vec_t vq[$];

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive_fifo();
    i_fifo_empty     = (fq.size() == 0);
    i_fifo_alm_empty = (fq.size() < BURST_LEN);
    i_fifo_rddata    = (fq.size() == 0) ? {DATA_W/16{16'hDEAD}} : fq[0];
  endtask

  task automatic push(input logic [DATA_W-1:0] v);
    fq.push_back(v);
    sb.push_back(v);
    drive_fifo();
  endtask

  // After a reset whatever was popped but not accepted is lost; the expected
  // stream restarts at the FIFO head.
  task automatic mon_reset();
    sb    = fq;
    pos   = 0;
    cnt_m = '0;
  endtask

  // One clock cycle, entered and left at a falling edge with inputs applied.
  task automatic cycle();
    logic pv, pr, pf, pl;
    logic [DATA_W-1:0] pd, ev, dummy;
    #1;
    rden_now = o_fifo_rden;
    pv = o_valid; pr = i_ready; pf = o_first; pl = o_last; pd = o_data;
    if (rden_now) chk1("rden_nonempty", i_fifo_empty, 1'b0);
    if (pv && !pr) chk1("rden_stall", rden_now, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (rden_now && fq.size() > 0) begin
      dummy = fq.pop_front();
      pops++;
    end
    drive_fifo();
    if (pv && !pr) begin
      chk1("hold_valid", o_valid, 1'b1);
      chkw("hold_data", o_data, pd);
      chk1("hold_first", o_first, pf);
      chk1("hold_last", o_last, pl);
    end
    if (pv && pr) begin
      acc++;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL beat_unexpected: got %h want none", pd);
      end else begin
        ev = sb.pop_front();
        chkw("beat_data", pd, ev);
      end
      if (pos == 0) begin
        chk1("first_at_start", pf, 1'b1);
        if (!pl) pos = 1;
      end else begin
        chk1("first_mid", pf, 1'b0);
        chk1("last_pos", pl, (pos == BURST_LEN-1));
        pos = (pos == BURST_LEN-1) ? 0 : pos + 1;
      end
      if (pl) cnt_m = cnt_m + 16'd1;
    end
    chk16("burst_cnt", o_burst_cnt, cnt_m);
  endtask

  task automatic step(input logic en, input logic rdy);
    i_en = en;
    i_ready = rdy;
    cycle();
  endtask

  // Reset asserted mid-cycle; all outputs must clear without a clock edge.
  task automatic do_reset();
    #2 rstn = 1'b0;
    #1;
    chk1("rst_valid", o_valid, 1'b0);
    chk1("rst_first", o_first, 1'b0);
    chk1("rst_last", o_last, 1'b0);
    chk1("rst_busy", o_busy, 1'b0);
    chk1("rst_rden", o_fifo_rden, 1'b0);
    chkw("rst_data", o_data, '0);
    chk16("rst_cnt", o_burst_cnt, 16'd0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    mon_reset();
  endtask

  function automatic vec_t mk(logic s, logic en, logic rdy, logic rden, logic vld,
                              int didx, logic f, logic l, logic [15:0] c);
    vec_t v;
    v.start = s; v.en = en; v.rdy = rdy; v.rden = rden; v.vld = vld;
    v.didx = didx; v.first = f; v.last = l; v.cnt = c;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pop;
    logic got;
    for (int i = 0; i < 8; i++) dv[i] = {4{32'h1111_1111 * (i + 1)}};

    // Full burst A..D, then the same with a 3-cycle stall while B is shown.
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 2, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 3, 0, 1, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 2, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 1, 3, 0, 1, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 1));

    rstn = 1'b0;
    drive_fifo();
    mon_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Reset with empty FIFO, then no pops for 100 cycles.
    for (int k = 0; k < 3; k++) step(1, 1);
    do_reset();
    for (int k = 0; k < 100; k++) begin
      step(1, 1);
      chk1("idle_no_rden", rden_now, 1'b0);
    end

    // Table-driven burst / backpressure sequences.
    foreach (vq[r]) begin
      if (vq[r].start) begin
        fq.delete(); sb.delete();
        do_reset();
        for (int i = 0; i < 4; i++) push(dv[i]);
      end
      i_en = vq[r].en;
      i_ready = vq[r].rdy;
      #1;
      chk1($sformatf("t%0d_rden", r), o_fifo_rden, vq[r].rden);
      chk1($sformatf("t%0d_valid", r), o_valid, vq[r].vld);
      if (vq[r].vld) begin
        chkw($sformatf("t%0d_data", r), o_data, dv[vq[r].didx]);
        chk1($sformatf("t%0d_first", r), o_first, vq[r].first);
        chk1($sformatf("t%0d_last", r), o_last, vq[r].last);
      end
      chk16($sformatf("t%0d_cnt", r), o_burst_cnt, vq[r].cnt);
      cycle();
    end

    // Enable dropped after the first beat: burst completes, no new one starts.
    fq.delete(); sb.delete();
    do_reset();
    for (int i = 0; i < 8; i++) push(dv[i]);
    pops = 0; acc = 0;
    step(1, 1); step(1, 1);
    for (int k = 0; k < 40; k++) step(0, 1);
    chki("en_low_pops", pops, 4);
    chki("en_low_beats", acc, 4);
    chk1("en_low_busy", o_busy, 1'b0);
    for (int k = 0; k < 14; k++) step(1, 1);
    chki("en_high_pops", pops, 8);
    chki("en_high_beats", acc, 8);
    chk16("en_high_cnt", o_burst_cnt, 16'd2);

    // Timeout flush of a single straggler.
    fq.delete(); sb.delete();
    do_reset();
    push(dv[5]);
    first_pop = -1;
    for (int k = 0; k < 40 && first_pop < 0; k++) begin
      step(1, 1);
      if (rden_now) first_pop = k;
    end
    checks++;
    if (first_pop < TIMEOUT + 1 || first_pop > TIMEOUT + 2) begin
      failures++;
      $display("FAIL flush_delay: got %0d want %0d..%0d", first_pop, TIMEOUT + 1, TIMEOUT + 2);
    end
    chk1("flush_valid", o_valid, 1'b1);
    chkw("flush_data", o_data, dv[5]);
    chk1("flush_first", o_first, 1'b1);
    chk1("flush_last", o_last, 1'b1);
    for (int k = 0; k < 4; k++) step(1, 1);
    chk1("flush_idle", o_busy, 1'b0);
    chk16("flush_cnt", o_burst_cnt, 16'd1);

    // Reset after two accepted beats; next burst starts at the FIFO head.
    fq.delete(); sb.delete();
    do_reset();
    for (int i = 0; i < 8; i++) push(dv[i]);
    for (int k = 0; k < 4; k++) step(1, 1);
    do_reset();
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      step(1, 1);
      if (o_valid) got = 1'b1;
    end
    chk1("rst_next_valid", got, 1'b1);
    chkw("rst_next_data", o_data, dv[3]);
    chk1("rst_next_first", o_first, 1'b1);
    for (int k = 0; k < 20; k++) step(1, 1);

    // Randomized traffic against the scoreboard and framing rules.
    fq.delete(); sb.delete();
    do_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(99) < 30) push({$urandom(), $urandom(), $urandom(), $urandom()});
      step($urandom_range(9) != 0, $urandom_range(9) < 7);
    end
    for (int k = 0; k < 600 && sb.size() != 0; k++) step(1, 1);
    chki("drain_left", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
